// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty-cycle capture block.
package pwm_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE,
    MEASURE,
    DIVIDE
  } cap_state_t;

  localparam int unsigned PCT_BITS = 7;
  localparam logic [PCT_BITS-1:0] PCT_FULL = 7'd100;

endpackage

// File: rtl/seq_divider.sv
// Sequential compare-and-subtract divider, one quotient bit per clock.
module seq_divider #(
  parameter int unsigned DIVIDEND_W = 31,
  parameter int unsigned DIVISOR_W  = 24,
  parameter int unsigned QUOT_W     = 7
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [QUOT_W-1:0]     quotient
);

  localparam int unsigned CW = $clog2(QUOT_W + 1);

  logic [DIVIDEND_W-1:0] rem;
  logic [DIVIDEND_W-1:0] sdiv;
  logic [DIVIDEND_W-1:0] rem_next;
  logic [QUOT_W-1:0]     q;
  logic [CW-1:0]         iter;
  logic                  fits;

  // quotient is the value after the current iteration, so the caller can
  // register it on the same edge that retires the last iteration
  always_comb begin
    fits     = (rem >= sdiv);
    rem_next = fits ? (rem - sdiv) : rem;
    quotient = (q << 1) | QUOT_W'(fits);
    done     = busy && (iter == CW'(1));
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rem  <= '0;
      sdiv <= '0;
      q    <= '0;
      iter <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= dividend;
      sdiv <= DIVIDEND_W'(divisor) << (QUOT_W - 1);
      q    <= '0;
      iter <= CW'(QUOT_W);
      busy <= 1'b1;
    end else if (busy) begin
      rem  <= rem_next;
      sdiv <= sdiv >> 1;
      q    <= quotient;
      iter <= iter - CW'(1);
      if (iter == CW'(1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM duty cycle as an integer percentage with stale-input timeout.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned         CNT_BITS = 24,
  parameter logic [CNT_BITS-1:0] TIMEOUT  = 24'd12_000_000
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                pwm_in,
  input  logic                en,
  output logic [PCT_BITS-1:0] duty_cycle,
  output logic                valid,
  output logic                stale,
  output logic                missed
);

  localparam int unsigned         DW         = CNT_BITS + 7;
  localparam logic [CNT_BITS-1:0] TIMEOUT_M1 = TIMEOUT - CNT_BITS'(1);

  cap_state_t          state;
  logic                s1, s2, s3;
  logic                rise;
  logic [CNT_BITS-1:0] period_cnt;
  logic [CNT_BITS-1:0] high_cnt;
  logic [DW-1:0]       high_ext;
  logic [DW-1:0]       dividend;
  logic                timeout_hit;
  logic                div_start;
  logic                div_busy;
  logic                div_done;
  logic [PCT_BITS-1:0] div_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= CNT_BITS'(1);
      high_cnt   <= CNT_BITS'(1);
    end else begin
      if (period_cnt != TIMEOUT) begin
        period_cnt <= period_cnt + CNT_BITS'(1);
      end
      if (s2 && (high_cnt != TIMEOUT)) begin
        high_cnt <= high_cnt + CNT_BITS'(1);
      end
    end
  end

  // high*100 as shift-add; fires only on the edge where period_cnt reaches TIMEOUT
  always_comb begin
    rise        = s2 & ~s3;
    high_ext    = DW'(high_cnt);
    dividend    = (high_ext << 6) + (high_ext << 5) + (high_ext << 2);
    timeout_hit = !rise && (period_cnt == TIMEOUT_M1);
    div_start   = (state == MEASURE) && rise && en && !div_busy;
  end

  seq_divider #(
    .DIVIDEND_W (DW),
    .DIVISOR_W  (CNT_BITS),
    .QUOT_W     (PCT_BITS)
  ) u_div (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (period_cnt),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= WAIT_RISE;
      duty_cycle <= '0;
      valid      <= 1'b0;
      stale      <= 1'b0;
      missed     <= 1'b0;
    end else begin
      valid  <= 1'b0;
      missed <= 1'b0;
      case (state)
        WAIT_RISE, MEASURE: begin
          if (timeout_hit) begin
            duty_cycle <= s2 ? PCT_FULL : '0;
            valid      <= en;
            stale      <= 1'b1;
            state      <= WAIT_RISE;
          end else if (rise) begin
            if (state == WAIT_RISE) begin
              state <= MEASURE;
            end else if (div_start) begin
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          if (rise) begin
            missed <= 1'b1;
          end
          if (div_done) begin
            duty_cycle <= div_q;
            valid      <= 1'b1;
            stale      <= 1'b0;
            state      <= MEASURE;
          end
        end
        default: state <= WAIT_RISE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture against an event-level reference model.
module tb_pwm_capture;

  localparam int TO = 5000;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic       en = 1'b0;
  logic [6:0] duty_cycle;
  logic       valid;
  logic       stale;
  logic       missed;

  int pass_cnt = 0;
  int check_cnt = 0;
  int cur_edge = 0;
  string phase_name = "init";

  bit bits[$];
  bit ens[$];
  int acc_edges[$];
  int exp_valid[];
  int exp_missed[];
  int exp_duty[];
  int exp_stale[];

  pwm_capture #(
    .CNT_BITS (24),
    .TIMEOUT  (24'd5000)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .pwm_in     (pwm_in),
    .en         (en),
    .duty_cycle (duty_cycle),
    .valid      (valid),
    .stale      (stale),
    .missed     (missed)
  );

  always #5 clk = ~clk;

  initial begin
    #4000000;
    $display("FAIL watchdog phase=%s edge=%0d got=timeout want=finish", phase_name, cur_edge);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int got, input int want);
    check_cnt++;
    if (got == want) pass_cnt++;
    else $display("FAIL %s phase=%s edge=%0d got=%0d want=%0d", tag, phase_name, cur_edge, got, want);
  endtask

  task automatic add_level(input bit v, input int len, input bit e);
    for (int i = 0; i < len; i++) begin
      bits.push_back(v);
      ens.push_back(e);
    end
  endtask

  task automatic add_wave(input int period, input int high, input int reps, input bit e);
    for (int r = 0; r < reps; r++) begin
      add_level(1'b1, high, e);
      add_level(1'b0, period - high, e);
    end
  endtask

  // Edge k samples bits[k] into the first synchronizer flop. A rise in the
  // stimulus at index c is acted on at edge c+2; results land 7 edges later.
  task automatic build_model();
    int  n;
    int  prev_c;
    int  busy_a;
    int  upd[];
    int  upd_duty[];
    int  upd_stale[];
    bit  armed;
    int  cur_d;
    int  cur_s;
    n = bits.size();
    exp_valid  = new[n];
    exp_missed = new[n];
    exp_duty   = new[n];
    exp_stale  = new[n];
    upd        = new[n];
    upd_duty   = new[n];
    upd_stale  = new[n];
    acc_edges.delete();
    prev_c = -2;
    busy_a = -100;
    armed  = 1'b0;
    for (int c = 0; c <= n; c++) begin
      bit is_rise;
      int t;
      is_rise = (c < n) && bits[c] && ((c == 0) || !bits[c-1]);
      if (is_rise || c == n) begin
        if (c - prev_c >= TO) begin
          t = prev_c + TO + 1;
          if (t < n) begin
            upd[t]       = 1;
            upd_duty[t]  = (t >= 2 && bits[t-2]) ? 100 : 0;
            upd_stale[t] = 1;
            exp_valid[t] = int'(ens[t]);
          end
          armed = 1'b0;
        end
      end
      if (is_rise) begin
        int r;
        r = c + 2;
        if (r < n) begin
          if (r > busy_a && r <= busy_a + 7) begin
            exp_missed[r] = 1;
          end else if (!armed) begin
            armed = 1'b1;
          end else if (ens[r]) begin
            int high;
            high = 0;
            for (int i = prev_c; i < c; i++) high += int'(bits[i]);
            busy_a = r;
            acc_edges.push_back(r);
            if (r + 7 < n) begin
              upd[r+7]       = 1;
              upd_duty[r+7]  = (high * 100) / (c - prev_c);
              upd_stale[r+7] = 0;
              exp_valid[r+7] = 1;
            end
          end
        end
        prev_c = c;
      end
    end
    cur_d = 0;
    cur_s = 0;
    for (int e = 0; e < n; e++) begin
      if (upd[e] != 0) begin
        cur_d = upd_duty[e];
        cur_s = upd_stale[e];
      end
      exp_duty[e]  = cur_d;
      exp_stale[e] = cur_s;
    end
  endtask

  task automatic check_zero();
    check_eq("rst_duty", int'(duty_cycle), 0);
    check_eq("rst_valid", int'(valid), 0);
    check_eq("rst_stale", int'(stale), 0);
    check_eq("rst_missed", int'(missed), 0);
  endtask

  // Called at a negedge; returns at a negedge with reset released.
  task automatic reset_dut();
    clr_n = 1'b0;
    #1;
    check_zero();
    for (int i = 0; i < 6; i++) begin
      pwm_in = ~pwm_in;
      en = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_zero();
    end
    pwm_in = 1'b0;
    clr_n = 1'b1;
  endtask

  task automatic run_phase(input string name, input int stop_acc);
    int n;
    int stop_edge;
    phase_name = name;
    build_model();
    n = bits.size();
    stop_edge = n - 1;
    if (stop_acc >= 0) begin
      if (stop_acc < acc_edges.size()) stop_edge = acc_edges[stop_acc] + 3;
      else check_eq("model_has_accept", acc_edges.size(), stop_acc + 1);
    end
    for (int k = 0; k <= stop_edge; k++) begin
      pwm_in = bits[k];
      en = ens[k];
      @(posedge clk);
      @(negedge clk);
      cur_edge = k;
      check_eq("valid", int'(valid), exp_valid[k]);
      check_eq("missed", int'(missed), exp_missed[k]);
      check_eq("duty", int'(duty_cycle), exp_duty[k]);
      check_eq("stale", int'(stale), exp_stale[k]);
    end
    bits.delete();
    ens.delete();
  endtask

  initial begin
    @(negedge clk);
    reset_dut();

    add_level(1'b0, 10, 1'b1);
    add_wave(1000, 250, 5, 1'b1);
    run_phase("duty25", -1);

    reset_dut();
    add_level(1'b0, 5, 1'b1);
    add_wave(1000, 999, 3, 1'b1);
    add_wave(3, 1, 8, 1'b1);
    add_wave(2, 1, 8, 1'b1);
    add_wave(9, 8, 4, 1'b1);
    add_wave(40, 39, 3, 1'b1);
    run_phase("floor_edges", -1);

    reset_dut();
    add_level(1'b0, 10, 1'b1);
    add_level(1'b1, 5200, 1'b1);
    add_level(1'b0, 50, 1'b1);
    add_wave(100, 30, 4, 1'b1);
    run_phase("timeout_high", -1);

    reset_dut();
    add_level(1'b0, 5100, 1'b1);
    add_wave(100, 70, 3, 1'b1);
    run_phase("timeout_low", -1);

    reset_dut();
    add_level(1'b0, 5, 1'b1);
    add_wave(5, 2, 40, 1'b1);
    run_phase("short_period", -1);

    reset_dut();
    add_level(1'b0, 5, 1'b1);
    while (bits.size() < 7000) begin
      int p;
      int h;
      bit e;
      if ($urandom_range(0, 6) == 0) p = $urandom_range(2, 9);
      else p = $urandom_range(2, 400);
      h = $urandom_range(1, p - 1);
      e = ($urandom_range(0, 9) != 0);
      add_wave(p, h, 1, e);
    end
    run_phase("random", -1);

    reset_dut();
    add_level(1'b0, 5, 1'b1);
    add_wave(40, 10, 5, 1'b1);
    run_phase("mid_divide", 1);
    reset_dut();
    add_level(1'b0, 3, 1'b1);
    add_wave(50, 20, 4, 1'b1);
    run_phase("after_abort", -1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
